// File: rtl/pipe_wb_regfile_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_wb_regfile_if
//  Description : MEM/WB write-back bundle plus ID-stage read ports and status
//                outputs of the write-back register file.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_wb_regfile_if;
  logic [31:0] WB_npc;
  logic        WB_LW;
  logic        WB_JAL;
  logic        WB_MUL;
  logic [31:0] WB_aluc;
  logic [31:0] WB_MUL_res;
  logic [31:0] WB_DM_rdata;
  logic        WB_RF_W_ena;
  logic [4:0]  WB_RF_waddr;
  logic [4:0]  ID_raddr1;
  logic [4:0]  ID_raddr2;
  logic [31:0] ID_rdata1;
  logic [31:0] ID_rdata2;
  logic [31:0] WB_wdata;
  logic        WB_commit;
  logic [31:0] retire_cnt;

  // Upstream side: drives the WB bundle and read addresses
  modport master (
    output WB_npc, WB_LW, WB_JAL, WB_MUL, WB_aluc, WB_MUL_res, WB_DM_rdata,
           WB_RF_W_ena, WB_RF_waddr, ID_raddr1, ID_raddr2,
    input  ID_rdata1, ID_rdata2, WB_wdata, WB_commit, retire_cnt
  );

  // Register-file side
  modport slave (
    input  WB_npc, WB_LW, WB_JAL, WB_MUL, WB_aluc, WB_MUL_res, WB_DM_rdata,
           WB_RF_W_ena, WB_RF_waddr, ID_raddr1, ID_raddr2,
    output ID_rdata1, ID_rdata2, WB_wdata, WB_commit, retire_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_wb_regfile
//  Description : Write-back stage: selects the write-back value, commits it to
//                a 32 x 32 register file with write-through bypass on two
//                combinational read ports, and counts committed writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_wb_regfile #(
  parameter logic [31:0] SP_INIT = 32'h0000_0000,
  parameter logic [31:0] GP_INIT = 32'h0000_0000
) (
  input  wire logic         clk,
  input  wire logic         rst,
  pipe_wb_regfile_if.slave  bus
);

  localparam int unsigned REG_GP = 28;
  localparam int unsigned REG_SP = 29;

  // r0 is hardwired to zero, so only r1..r31 have storage
  logic [31:0] regs_q [31:1];
  logic [31:0] retire_cnt_q;
  logic [31:0] retire_cnt_d;
  logic [31:0] wdata;
  logic        commit;

  // Fixed-priority write-back select: load, then link, then multiply, then ALU
  always_comb begin
    wdata = bus.WB_aluc;
    if (bus.WB_LW)       wdata = bus.WB_DM_rdata;
    else if (bus.WB_JAL) wdata = bus.WB_npc;
    else if (bus.WB_MUL) wdata = bus.WB_MUL_res;
  end

  // A write is real only when enabled, not aimed at r0, and not in reset
  assign commit = bus.WB_RF_W_ena & (bus.WB_RF_waddr != 5'd0) & ~rst;

  // Register array: async reset to boot values, single write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        if (i == REG_GP)      regs_q[i] <= GP_INIT;
        else if (i == REG_SP) regs_q[i] <= SP_INIT;
        else                  regs_q[i] <= 32'h0000_0000;
      end
    end else if (commit) begin
      regs_q[bus.WB_RF_waddr] <= wdata;
    end
  end

  // One read port: r0 reads zero, same-cycle write is forwarded through
  function automatic logic [31:0] read_port(input logic [4:0] raddr);
    logic [31:0] val;
    val = 32'h0000_0000;
    if (raddr != 5'd0) begin
      if (commit && (raddr == bus.WB_RF_waddr)) val = wdata;
      else                                      val = regs_q[raddr];
    end
    return val;
  endfunction

  // Both read ports share identical bypass logic
  always_comb begin
    bus.ID_rdata1 = read_port(bus.ID_raddr1);
    bus.ID_rdata2 = read_port(bus.ID_raddr2);
  end

  // Committed-write counter next state; wraps naturally at 2^32
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (commit) retire_cnt_d = retire_cnt_q + 32'd1;
  end

  // Committed-write counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) retire_cnt_q <= 32'h0000_0000;
    else     retire_cnt_q <= retire_cnt_d;
  end

  assign bus.WB_wdata   = wdata;
  assign bus.WB_commit  = commit;
  assign bus.retire_cnt = retire_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_wb_regfile
//  Description : Self-checking bench for pipe_wb_regfile with a behavioural
//                register-file model and randomized write-back traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_wb_regfile;

  localparam logic [31:0] SP_INIT = 32'h0000_3FFC;
  localparam logic [31:0] GP_INIT = 32'h1000_8000;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  logic [31:0] ref_rf [32];
  logic [31:0] ref_cnt;

  pipe_wb_regfile_if bus ();

  pipe_wb_regfile #(.SP_INIT(SP_INIT), .GP_INIT(GP_INIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < 32; i++) ref_rf[i] = 32'h0;
    ref_rf[28] = GP_INIT;
    ref_rf[29] = SP_INIT;
    ref_cnt    = 32'h0;
  endtask

  function automatic logic [31:0] exp_wdata();
    if (bus.WB_LW)  return bus.WB_DM_rdata;
    if (bus.WB_JAL) return bus.WB_npc;
    if (bus.WB_MUL) return bus.WB_MUL_res;
    return bus.WB_aluc;
  endfunction

  function automatic logic exp_commit();
    return bus.WB_RF_W_ena && (bus.WB_RF_waddr != 5'd0) && !rst;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (exp_commit() && a == bus.WB_RF_waddr) return exp_wdata();
    return ref_rf[a];
  endfunction

  // Advance one clock: model commits what the DUT should, then return at negedge
  task automatic tick();
    logic        c;
    logic [31:0] d;
    logic [4:0]  a;
    c = exp_commit();
    d = exp_wdata();
    a = bus.WB_RF_waddr;
    @(posedge clk);
    if (c) begin
      ref_rf[a] = d;
      ref_cnt   = ref_cnt + 32'd1;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic ena, input logic [4:0] waddr,
                       input logic lw, input logic jal, input logic mul,
                       input logic [31:0] aluc, input logic [31:0] mres,
                       input logic [31:0] npc, input logic [31:0] dm);
    bus.WB_RF_W_ena = ena;
    bus.WB_RF_waddr = waddr;
    bus.WB_LW       = lw;
    bus.WB_JAL      = jal;
    bus.WB_MUL      = mul;
    bus.WB_aluc     = aluc;
    bus.WB_MUL_res  = mres;
    bus.WB_npc      = npc;
    bus.WB_DM_rdata = dm;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    drive(1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 32'hAAAA_5555, 32'h0, 32'h0, 32'h0);
    bus.ID_raddr1 = 5'd29;
    bus.ID_raddr2 = 5'd5;
    @(negedge clk);
    #1;
    n_cmp++; if (bus.ID_rdata1 !== SP_INIT) begin n_bad++; $display("FAIL reset_r29 got %h exp %h", bus.ID_rdata1, SP_INIT); end
    n_cmp++; if (bus.ID_rdata2 !== 32'h0) begin n_bad++; $display("FAIL reset_r5 got %h exp 0", bus.ID_rdata2); end
    n_cmp++; if (bus.retire_cnt !== 32'h0) begin n_bad++; $display("FAIL reset_cnt got %h exp 0", bus.retire_cnt); end
    n_cmp++; if (bus.WB_commit !== 1'b0) begin n_bad++; $display("FAIL reset_commit got %b exp 0", bus.WB_commit); end
    n_cmp++; if (bus.WB_wdata !== 32'hAAAA_5555) begin n_bad++; $display("FAIL reset_wdata got %h exp aaaa5555", bus.WB_wdata); end
    bus.ID_raddr1 = 5'd28;
    @(posedge clk); #1;
    n_cmp++; if (bus.ID_rdata1 !== GP_INIT) begin n_bad++; $display("FAIL reset_r28 got %h exp %h", bus.ID_rdata1, GP_INIT); end
    n_cmp++; if (bus.ID_rdata2 !== 32'h0) begin n_bad++; $display("FAIL reset_nowrite got %h exp 0", bus.ID_rdata2); end
    @(negedge clk);
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mux_priority();
    logic [2:0]  sel [4];
    logic [31:0] cnt0;
    sel[0] = 3'b000; sel[1] = 3'b001; sel[2] = 3'b011; sel[3] = 3'b110; // {LW,JAL,MUL}
    cnt0 = bus.retire_cnt;
    bus.ID_raddr1 = 5'd7;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd7, sel[i][2], sel[i][1], sel[i][0], 32'd1, 32'd2, 32'd3, 32'd4);
      #1;
      n_cmp++; if (bus.WB_wdata !== 32'(i + 1)) begin n_bad++; $display("FAIL mux_wdata sel%0d got %h exp %h", i, bus.WB_wdata, 32'(i + 1)); end
      n_cmp++; if (bus.ID_rdata1 !== 32'(i + 1)) begin n_bad++; $display("FAIL mux_bypass sel%0d got %h exp %h", i, bus.ID_rdata1, 32'(i + 1)); end
      tick();
    end
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    #1;
    n_cmp++; if (bus.ID_rdata1 !== 32'd4) begin n_bad++; $display("FAIL mux_r7 got %h exp 4", bus.ID_rdata1); end
    n_cmp++; if (bus.retire_cnt !== cnt0 + 32'd4) begin n_bad++; $display("FAIL mux_cnt got %h exp %h", bus.retire_cnt, cnt0 + 32'd4); end
    n_cmp++; if (bus.WB_wdata !== 32'h0) begin n_bad++; $display("FAIL bubble_wdata got %h exp 0", bus.WB_wdata); end
  endtask

  task automatic test_r0();
    logic [31:0] cnt0;
    cnt0 = bus.retire_cnt;
    drive(1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0);
    bus.ID_raddr1 = 5'd0;
    #1;
    n_cmp++; if (bus.ID_rdata1 !== 32'h0) begin n_bad++; $display("FAIL r0_same got %h exp 0", bus.ID_rdata1); end
    n_cmp++; if (bus.WB_commit !== 1'b0) begin n_bad++; $display("FAIL r0_commit got %b exp 0", bus.WB_commit); end
    tick();
    #1;
    n_cmp++; if (bus.ID_rdata1 !== 32'h0) begin n_bad++; $display("FAIL r0_next got %h exp 0", bus.ID_rdata1); end
    n_cmp++; if (bus.retire_cnt !== cnt0) begin n_bad++; $display("FAIL r0_cnt got %h exp %h", bus.retire_cnt, cnt0); end
  endtask

  task automatic test_bypass();
    drive(1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 32'h11, 32'h0, 32'h0, 32'h0);
    tick();
    drive(1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 32'h22, 32'h0, 32'h0, 32'h0);
    bus.ID_raddr1 = 5'd9;
    bus.ID_raddr2 = 5'd9;
    #1;
    n_cmp++; if (bus.ID_rdata1 !== 32'h22) begin n_bad++; $display("FAIL byp_p1_pre got %h exp 22", bus.ID_rdata1); end
    n_cmp++; if (bus.ID_rdata2 !== 32'h22) begin n_bad++; $display("FAIL byp_p2_pre got %h exp 22", bus.ID_rdata2); end
    tick();
    drive(1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 32'h33, 32'h0, 32'h0, 32'h0);
    #1;
    n_cmp++; if (bus.ID_rdata1 !== 32'h22) begin n_bad++; $display("FAIL byp_p1_post got %h exp 22", bus.ID_rdata1); end
    n_cmp++; if (bus.ID_rdata2 !== 32'h22) begin n_bad++; $display("FAIL byp_p2_post got %h exp 22", bus.ID_rdata2); end
  endtask

  task automatic test_counter_wrap();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    ref_cnt = 32'hFFFF_FFFF;
    #1;
    n_cmp++; if (bus.retire_cnt !== ref_cnt) begin n_bad++; $display("FAIL wrap_preload got %h exp %h", bus.retire_cnt, ref_cnt); end
    drive(1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 32'h5, 32'h0, 32'h0, 32'h0);
    tick();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    #1;
    n_cmp++; if (bus.retire_cnt !== 32'h0) begin n_bad++; $display("FAIL wrap_cnt got %h exp 0", bus.retire_cnt); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
            1'($urandom), 1'($urandom), 1'($urandom),
            $urandom, $urandom, $urandom, $urandom);
      if ($urandom_range(0, 7) == 0) bus.WB_RF_waddr = 5'd0;
      bus.ID_raddr1 = ($urandom_range(0, 2) == 0) ? bus.WB_RF_waddr : 5'($urandom_range(0, 31));
      bus.ID_raddr2 = ($urandom_range(0, 2) == 0) ? bus.WB_RF_waddr : 5'($urandom_range(0, 31));
      #1;
      n_cmp++; if (bus.WB_wdata !== exp_wdata()) begin n_bad++; $display("FAIL rnd_wdata it%0d got %h exp %h", n, bus.WB_wdata, exp_wdata()); end
      n_cmp++; if (bus.WB_commit !== exp_commit()) begin n_bad++; $display("FAIL rnd_commit it%0d got %b exp %b", n, bus.WB_commit, exp_commit()); end
      n_cmp++; if (bus.ID_rdata1 !== exp_read(bus.ID_raddr1)) begin n_bad++; $display("FAIL rnd_rd1 it%0d a=%0d got %h exp %h", n, bus.ID_raddr1, bus.ID_rdata1, exp_read(bus.ID_raddr1)); end
      n_cmp++; if (bus.ID_rdata2 !== exp_read(bus.ID_raddr2)) begin n_bad++; $display("FAIL rnd_rd2 it%0d a=%0d got %h exp %h", n, bus.ID_raddr2, bus.ID_rdata2, exp_read(bus.ID_raddr2)); end
      n_cmp++; if (bus.retire_cnt !== ref_cnt) begin n_bad++; $display("FAIL rnd_cnt it%0d got %h exp %h", n, bus.retire_cnt, ref_cnt); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 5'd12, 1'b0, 1'b0, 1'b0, 32'hCAFE_0012, 32'h0, 32'h0, 32'h0);
    tick();
    drive(1'b1, 5'd12, 1'b0, 1'b0, 1'b0, 32'h0BAD_0012, 32'h0, 32'h0, 32'h0);
    bus.ID_raddr1 = 5'd12;
    bus.ID_raddr2 = 5'd29;
    #1;
    n_cmp++; if (bus.WB_commit !== 1'b1) begin n_bad++; $display("FAIL arst_pre_commit got %b exp 1", bus.WB_commit); end
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    n_cmp++; if (bus.ID_rdata1 !== 32'h0) begin n_bad++; $display("FAIL arst_r12 got %h exp 0", bus.ID_rdata1); end
    n_cmp++; if (bus.ID_rdata2 !== SP_INIT) begin n_bad++; $display("FAIL arst_r29 got %h exp %h", bus.ID_rdata2, SP_INIT); end
    n_cmp++; if (bus.WB_commit !== 1'b0) begin n_bad++; $display("FAIL arst_commit got %b exp 0", bus.WB_commit); end
    n_cmp++; if (bus.retire_cnt !== 32'h0) begin n_bad++; $display("FAIL arst_cnt got %h exp 0", bus.retire_cnt); end
    @(posedge clk); #1;
    n_cmp++; if (bus.ID_rdata1 !== 32'h0) begin n_bad++; $display("FAIL arst_hold_r12 got %h exp 0", bus.ID_rdata1); end
    n_cmp++; if (bus.retire_cnt !== 32'h0) begin n_bad++; $display("FAIL arst_hold_cnt got %h exp 0", bus.retire_cnt); end
    @(negedge clk);
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++; if (bus.ID_rdata1 !== 32'h0) begin n_bad++; $display("FAIL arst_after_r12 got %h exp 0", bus.ID_rdata1); end
  endtask

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    bus.ID_raddr1 = 5'd0;
    bus.ID_raddr2 = 5'd0;
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    test_reset();
    test_mux_priority();
    test_r0();
    test_bypass();
    test_random();
    test_counter_wrap();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_wb_regfile.md
Name: pipe_wb_regfile

Overview:
Write-back end of the MEM/WB pipeline interface. Consumes the registered WB_* bundle and selects the write-back value. Commits that value into a 32 x 32-bit register file and serves two combinational read ports to the ID stage, with write-through bypass. Also keeps a count of committed register writes for performance and debug.

Parameters:
SP_INIT, 32'h0000_0000, reset value of register 29 (stack pointer).
GP_INIT, 32'h0000_0000, reset value of register 28 (global pointer).

Ports:
clk  input  1  pipeline clock; all state updates on posedge.
rst  input  1  asynchronous, active-high reset.
WB_npc  input  32  link value for JAL.
WB_LW  input  1  selects WB_DM_rdata as write data.
WB_JAL  input  1  selects WB_npc as write data.
WB_MUL  input  1  selects WB_MUL_res as write data.
WB_aluc  input  32  ALU result (default write data).
WB_MUL_res  input  32  multiplier low word.
WB_DM_rdata  input  32  data-memory load data.
WB_RF_W_ena  input  1  register write request.
WB_RF_waddr  input  5  destination register.
ID_raddr1  input  5  read port 1 address.
ID_raddr2  input  5  read port 2 address.
ID_rdata1  output  32  read port 1 data (combinational).
ID_rdata2  output  32  read port 2 data (combinational).
WB_wdata  output  32  selected write-back value, exported for EX/MEM forwarding.
WB_commit  output  1  high when a real write occurs this cycle.
retire_cnt  output  32  committed-write counter.

Behaviour:
- Reset: asynchronous, active-high. While rst=1:
  - all registers are 0, except r28=GP_INIT and r29=SP_INIT;
  - retire_cnt=0.
- Combinational outputs during reset:
  - WB_wdata still follows the mux.
  - WB_commit is forced 0.
  - Read ports return the reset register values with no bypass.
- Write-data mux, combinational, fixed priority:
  - WB_LW -> WB_DM_rdata;
  - else WB_JAL -> WB_npc;
  - else WB_MUL -> WB_MUL_res;
  - else WB_aluc.
  - Several selects high at once is resolved by this priority and is not an error.
- WB_commit = WB_RF_W_ena & (WB_RF_waddr != 0) & ~rst.
- Register write: on posedge clk, if WB_commit, reg[WB_RF_waddr] <= WB_wdata.
  - Zero latency: visible to sequential reads from the next cycle, and to combinational reads in the same cycle via bypass.
- Register 0:
  - hardwired 0; reads always return 0;
  - writes to r0 are discarded and do not count toward retire_cnt.
- Read port n (identical logic for both):
  - raddr==0 -> 0;
  - else if WB_commit and raddr==WB_RF_waddr -> WB_wdata (write-through bypass);
  - else reg[raddr].
  - Both ports may address the same register, and both bypass independently.
- retire_cnt: increments by 1 on each posedge where WB_commit=1.
  - Wraps 32'hFFFF_FFFF -> 0 silently.
- Inputs are assumed registered by the upstream MEM/WB stage. The block adds no pipeline register on the write path.
- Reset asserted mid-stream: any write pending in that cycle is lost. Register state and counter return to reset values immediately, without waiting for a clock edge.
- Bubble/flush from upstream (all-zero WB bundle): no write, no count.
  - WB_wdata equals WB_aluc, i.e. 0 for an all-zero bundle.

Test Plan:
1. Reset values: assert rst with SP_INIT=32'h0000_3FFC.
   -> ID_rdata for r29 = 32'h0000_3FFC; r5 = 0; retire_cnt=0; WB_commit=0.
2. Mux priority: WB_aluc=1, WB_MUL_res=2, WB_npc=3, WB_DM_rdata=4, W_ena=1, waddr=7.
   - Step selects through {none, MUL, JAL+MUL, LW+JAL}.
   -> r7 reads 1, 2, 3, 4 on successive cycles; retire_cnt advances by 4.
3. r0 protection: W_ena=1, waddr=0, WB_aluc=32'hDEAD_BEEF.
   -> ID_rdata1(raddr=0)=0 in the same and following cycles; WB_commit=0; retire_cnt unchanged.
4. Bypass: r9 holds 32'h11; drive W_ena=1, waddr=9, WB_aluc=32'h22, ID_raddr1=ID_raddr2=9.
   -> both ports show 32'h22 before the clock edge; after the edge with W_ena=0, both still read 32'h22.
5. Counter wrap: force 2^32-1 commits (or preload via a testbench hierarchical force to 32'hFFFF_FFFF), then one more write.
   -> retire_cnt = 0.
6. Async reset mid-operation: W_ena=1 to r12, then assert rst between clock edges.
   -> r12 reads 0 immediately with no clock edge; WB_commit drops to 0; no write occurs at the following posedge while rst is held.
